// File: rtl/poly_sequencer.sv
// poly_sequencer
//
// Sequences the shared two-register ALU datapath (RA/RB, operand muxes, add/mul ALU)
// to evaluate f = a*x^2 + b*x + c using Horner's rule: ((a*x) + b)*x + c.
// The sequencer owns the datapath x bus and drives x, a, b and c onto it in turn.
// After reset it waits in IDLE. In DONE the datapath output f holds the result.
//
// Optional feature: define POLY_SEQ_ABORT_EN to add the abort input, which cancels
// a running sequence and returns the machine to IDLE.
//
// Ports:
//   clock   in   rising-edge system clock
//   resetn  in   asynchronous active-low reset
//   start   in   level-sensitive request, accepted in IDLE or DONE
//   abort   in   (POLY_SEQ_ABORT_EN only) cancel a busy sequence
//   x       in   operand, captured on accept
//   coef_a  in   x^2 coefficient, captured on accept
//   coef_b  in   x coefficient, captured on accept
//   coef_c  in   constant term, captured on accept
//   busy    out  high from CLEAR through ADD_C
//   done    out  high in DONE; datapath f is valid
//   dp_x    out  datapath x bus
//   selxA   out  ALU operand 1 select: 0 = dp_x, 1 = RA
//   selAB   out  ALU operand 2 select: 0 = RA, 1 = RB
//   LdRA    out  load RA with the ALU result
//   LdRB    out  load RB with the ALU result
//   ALUop   out  0 = add, 1 = multiply

module poly_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
`ifdef POLY_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] coef_a,
    input  logic [WIDTH-1:0] coef_b,
    input  logic [WIDTH-1:0] coef_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dp_x,
    output logic             selxA,
    output logic             selAB,
    output logic             LdRA,
    output logic             LdRB,
    output logic             ALUop
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StLoadX = 3'd2,
        StMulA  = 3'd3,
        StAddB  = 3'd4,
        StMulX  = 3'd5,
        StAddC  = 3'd6,
        StDone  = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] x_q, a_q, b_q, c_q;
    logic             accept;
    logic             abort_hit;

`ifdef POLY_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    // A new sequence can only be accepted from a resting state.
    assign accept = start && ((state_q == StIdle) || (state_q == StDone));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are latched only on accept so the bus is stable for the whole run.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x_q <= '0;
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else if (accept) begin
            x_q <= x;
            a_q <= coef_a;
            b_q <= coef_b;
            c_q <= coef_c;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        dp_x    = '0;
        selxA   = 1'b0;
        selAB   = 1'b0;
        LdRA    = 1'b0;
        LdRB    = 1'b0;
        ALUop   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                // 0 * RA clears both registers regardless of their contents.
                busy    = 1'b1;
                ALUop   = 1'b1;
                LdRA    = 1'b1;
                LdRB    = 1'b1;
                state_d = StLoadX;
            end
            StLoadX: begin
                // RB = x + RA, with RA already zero.
                busy    = 1'b1;
                dp_x    = x_q;
                LdRB    = 1'b1;
                state_d = StMulA;
            end
            StMulA: begin
                // RA = a * RB.
                busy    = 1'b1;
                dp_x    = a_q;
                selAB   = 1'b1;
                ALUop   = 1'b1;
                LdRA    = 1'b1;
                state_d = StAddB;
            end
            StAddB: begin
                busy    = 1'b1;
                dp_x    = b_q;
                LdRA    = 1'b1;
                state_d = StMulX;
            end
            StMulX: begin
                // RA = RA * RB, bus unused.
                busy    = 1'b1;
                selxA   = 1'b1;
                selAB   = 1'b1;
                ALUop   = 1'b1;
                LdRA    = 1'b1;
                state_d = StAddC;
            end
            StAddC: begin
                busy    = 1'b1;
                dp_x    = c_q;
                LdRA    = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                // Bus is zero and ALU adds, so datapath f = 0 + RA = result.
                done = 1'b1;
                if (start) begin
                    state_d = StClear;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort suppresses the pending register write so RA/RB keep their values.
        if (abort_hit && busy) begin
            state_d = StIdle;
            LdRA    = 1'b0;
            LdRB    = 1'b0;
        end
    end

endmodule

// File: tb/tb_poly_sequencer.sv
// Testbench for poly_sequencer. Includes a behavioural model of the shared
// RA/RB add/mul datapath driven by the sequencer's control lines. Results are
// compared with a*x^2 + b*x + c evaluated directly mod 256.

module tb_poly_sequencer;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [7:0] x, coef_a, coef_b, coef_c;
    logic       busy, done;
    logic [7:0] dp_x;
    logic       selxA, selAB, LdRA, LdRB, ALUop;
`ifdef POLY_SEQ_ABORT_EN
    logic       abort;
`endif

    int checks = 0;
    int errors = 0;

    poly_sequencer #(.WIDTH(8)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
`ifdef POLY_SEQ_ABORT_EN
        .abort  (abort),
`endif
        .x      (x),
        .coef_a (coef_a),
        .coef_b (coef_b),
        .coef_c (coef_c),
        .busy   (busy),
        .done   (done),
        .dp_x   (dp_x),
        .selxA  (selxA),
        .selAB  (selAB),
        .LdRA   (LdRA),
        .LdRB   (LdRB),
        .ALUop  (ALUop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Datapath model: two registers, operand muxes and an add/mul ALU.
    logic [7:0] ra, rb, op1, op2, f;
    logic [4:0] ctrl;

    assign ctrl = {selxA, selAB, ALUop, LdRA, LdRB};

    always_comb begin
        op1 = selxA ? ra : dp_x;
        op2 = selAB ? rb : ra;
        f   = ALUop ? 8'(op1 * op2) : 8'(op1 + op2);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ra <= 8'd0;
            rb <= 8'd0;
        end else begin
            if (LdRA) ra <= f;
            if (LdRB) rb <= f;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] poly(input logic [7:0] xv, av, bv, cv);
        int unsigned s;
        s = av * xv * xv + bv * xv + cv;
        return 8'(s % 256);
    endfunction

    // {selxA, selAB, ALUop, LdRA, LdRB} for the k-th busy cycle after accept.
    function automatic logic [4:0] ctrl_exp(input int k);
        case (k)
            1:       return 5'b00111;
            2:       return 5'b00001;
            3:       return 5'b01110;
            4:       return 5'b00010;
            5:       return 5'b11110;
            6:       return 5'b00010;
            default: return 5'b00000;
        endcase
    endfunction

    // Called just after an edge with the machine in IDLE or DONE. Ends #1 after
    // the edge that enters DONE. With hold set, start stays high and only x
    // changes (to nx) during the run; otherwise all inputs are scrambled.
    task automatic do_op(input logic [7:0] xv, av, bv, cv, input bit hold,
                         input logic [7:0] nx, input string tag);
        logic [7:0] er [7];
        logic [7:0] ed [7];
        logic [7:0] t;
        er[0] = 8'd0;
        er[1] = 8'd0;
        er[2] = 8'd0;
        t = av * xv;  er[3] = t;
        t = t + bv;   er[4] = t;
        t = t * xv;   er[5] = t;
        t = t + cv;   er[6] = t;
        ed[0] = 8'd0; ed[1] = 8'd0; ed[2] = xv; ed[3] = av;
        ed[4] = bv;   ed[5] = 8'd0; ed[6] = cv;

        x = xv; coef_a = av; coef_b = bv; coef_c = cv; start = 1'b1;
        @(posedge clock); #1;
        if (hold) begin
            x = nx;
        end else begin
            start  = 1'b0;
            x      = 8'($urandom);
            coef_a = 8'($urandom);
            coef_b = 8'($urandom);
            coef_c = 8'($urandom);
        end
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("%s/busy%0d", tag, k), 32'(busy), 32'd1);
            chk($sformatf("%s/done%0d", tag, k), 32'(done), 32'd0);
            chk($sformatf("%s/ctrl%0d", tag, k), 32'(ctrl), 32'(ctrl_exp(k)));
            chk($sformatf("%s/dpx%0d", tag, k), 32'(dp_x), 32'(ed[k]));
            if (k >= 2) chk($sformatf("%s/ra%0d", tag, k - 1), 32'(ra), 32'(er[k-1]));
            if (k == 3) chk($sformatf("%s/rb", tag), 32'(rb), 32'(xv));
            @(posedge clock); #1;
        end
        chk({tag, "/done"}, 32'(done), 32'd1);
        chk({tag, "/busy_end"}, 32'(busy), 32'd0);
        chk({tag, "/ctrl_end"}, 32'({ctrl, dp_x}), 32'd0);
        chk({tag, "/ra_end"}, 32'(ra), 32'(er[6]));
        chk({tag, "/f"}, 32'(f), 32'(poly(xv, av, bv, cv)));
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        x      = 8'd0;
        coef_a = 8'd0;
        coef_b = 8'd0;
        coef_c = 8'd0;
`ifdef POLY_SEQ_ABORT_EN
        abort  = 1'b0;
`endif
        #3;
        chk("reset_outs", 32'({busy, done, dp_x, ctrl}), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        // Directed values from the test plan.
        do_op(8'd5, 8'd1, 8'd2, 8'd0, 1'b0, 8'd0, "t1");
        @(posedge clock); #1;
        chk("t1/hold_done", 32'(done), 32'd1);
        chk("t1/hold_f", 32'(f), 32'd35);
        do_op(8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 8'd0, "t2");
        chk("t2/f25", 32'(f), 32'd25);
        do_op(8'd20, 8'd1, 8'd0, 8'd0, 1'b0, 8'd0, "t3a");
        chk("t3a/f144", 32'(f), 32'd144);
        do_op(8'd16, 8'd1, 8'd0, 8'd255, 1'b0, 8'd0, "t3b");
        chk("t3b/f255", 32'(f), 32'd255);

        // start held high: back-to-back runs, x changed mid-run each time.
        do_op(8'd1, 8'd1, 8'd1, 8'd1, 1'b1, 8'd3, "t4a");
        do_op(8'd3, 8'd1, 8'd1, 8'd1, 1'b1, 8'd7, "t4b");
        do_op(8'd7, 8'd1, 8'd1, 8'd1, 1'b0, 8'd0, "t4c");
        chk("t4c/f57", 32'(f), 32'd57);
        @(posedge clock); #1;
        chk("t4/stay_done", 32'(done), 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_op(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 8'd0,
                  $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in MUL_X.
        x = 8'd9; coef_a = 8'd2; coef_b = 8'd3; coef_c = 8'd4; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        chk("t5/in_mulx", 32'(ctrl), 32'b11110);
        #2;
        resetn = 1'b0;
        #1;
        chk("t5/async_outs", 32'({busy, done, dp_x, ctrl}), 32'd0);
        chk("t5/dp_ra", 32'(ra), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        chk("t5/idle_after", 32'({busy, done}), 32'd0);
        do_op(8'd5, 8'd1, 8'd2, 8'd0, 1'b0, 8'd0, "t5r");

`ifdef POLY_SEQ_ABORT_EN
        // Abort in DONE has no effect.
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        chk("t6/abort_done", 32'(done), 32'd1);
        // Abort during ADD_B.
        x = 8'd2; coef_a = 8'd3; coef_b = 8'd4; coef_c = 8'd5; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        abort = 1'b1;
        #1;
        chk("t6/busy_addb", 32'(busy), 32'd1);
        chk("t6/no_ldra", 32'(LdRA), 32'd0);
        chk("t6/no_ldrb", 32'(LdRB), 32'd0);
        @(posedge clock); #1;
        abort = 1'b0;
        chk("t6/idle", 32'(busy), 32'd0);
        chk("t6/ra_kept", 32'(ra), 32'd6);
        for (int i = 0; i < 8; i++) begin
            chk("t6/no_done", 32'(done), 32'd0);
            @(posedge clock); #1;
        end
        do_op(8'd2, 8'd3, 8'd4, 8'd5, 1'b0, 8'd0, "t6r");
        // start wins over abort in DONE.
        x = 8'd2; coef_a = 8'd3; coef_b = 8'd4; coef_c = 8'd5;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("t6/start_wins", 32'(busy), 32'd1);
        repeat (6) @(posedge clock);
        #1;
        chk("t6/sw_done", 32'(done), 32'd1);
        chk("t6/sw_f", 32'(f), 32'd25);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
